// File: rtl/bram_burst_ctrl.sv
// ============================================================================
// Module   : bram_burst_ctrl
// Purpose  : Burst controller owning one single-port BRAM: write bursts from a
//            valid/ready data stream, read bursts to a backpressured stream.
// Option   : BRAM_CTRL_WRAP_ERR_EN - reject bursts crossing RAM_DEPTH-1 (err_o)
// Revision : 1.0 - initial release
// ============================================================================
`timescale 1ns/1ps
`default_nettype none

module bram_burst_ctrl #(
    parameter int RAM_WIDTH  = 16,
    parameter int RAM_DEPTH  = 1024,
    parameter int ADDR_WIDTH = $clog2(RAM_DEPTH),
    parameter int LEN_WIDTH  = 8
) (
    input  logic                  clk,
    input  logic                  rst_n_i,
    input  logic                  cmd_valid_i,
    output logic                  cmd_ready_o,
    input  logic                  cmd_we_i,
    input  logic [ADDR_WIDTH-1:0] cmd_addr_i,
    input  logic [LEN_WIDTH-1:0]  cmd_len_i,
    input  logic                  wdata_valid_i,
    output logic                  wdata_ready_o,
    input  logic [RAM_WIDTH-1:0]  wdata_i,
    output logic                  rdata_valid_o,
    input  logic                  rdata_ready_i,
    output logic [RAM_WIDTH-1:0]  rdata_o,
    output logic                  rdata_last_o,
    output logic                  done_o,
    output logic                  bram_we_o,
    output logic                  bram_re_o,
    output logic [ADDR_WIDTH-1:0] bram_addr_o,
    output logic [RAM_WIDTH-1:0]  bram_din_o,
    input  logic [RAM_WIDTH-1:0]  bram_dout_i
`ifdef BRAM_CTRL_WRAP_ERR_EN
    ,
    output logic                  err_o
`endif
);

    localparam logic [ADDR_WIDTH-1:0] c_last_addr = ADDR_WIDTH'(RAM_DEPTH - 1);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_WRITE = 2'd1,
        S_READ  = 2'd2,
        S_DRAIN = 2'd3
    } state_t;

    state_t                state_q, state_d;
    logic [ADDR_WIDTH-1:0] addr_q, addr_d;
    logic [LEN_WIDTH-1:0]  rem_q, rem_d;
    logic                  done_q, done_d;

    logic [RAM_WIDTH-1:0]  mem_q [2];
    logic [1:0]            last_q;
    logic                  wptr_q, rptr_q;
    logic [1:0]            count_q, count_d;
    logic                  inflight_q, infl_last_q;

    logic [ADDR_WIDTH-1:0] w_addr_inc;
    logic                  w_accept, w_wbeat, w_pop, w_issue, w_capture;
    logic                  w_head_last, w_oob;
    logic [2:0]            w_credit;

    assign w_addr_inc = (addr_q == c_last_addr) ? '0 : addr_q + ADDR_WIDTH'(1);

    // done_q blocks acceptance so a new burst never starts in the done cycle
    assign cmd_ready_o   = rst_n_i && (state_q == S_IDLE) && !done_q;
    assign w_accept      = cmd_ready_o && cmd_valid_i;

    assign wdata_ready_o = rst_n_i && (state_q == S_WRITE);
    assign w_wbeat       = wdata_ready_o && wdata_valid_i;
    assign bram_we_o     = w_wbeat;
    assign bram_din_o    = w_wbeat ? wdata_i : '0;
    assign bram_addr_o   = addr_q;

    assign rdata_valid_o = (count_q != 2'd0);
    assign w_head_last   = last_q[rptr_q];
    assign rdata_o       = rdata_valid_o ? mem_q[rptr_q] : '0;
    assign rdata_last_o  = rdata_valid_o && w_head_last;
    assign w_pop         = rdata_valid_o && rdata_ready_i;
    assign w_capture     = inflight_q;

    // A beat leaving the FIFO this cycle frees its slot for a new issue
    assign w_credit  = {1'b0, count_q} + {2'b00, inflight_q};
    assign w_issue   = rst_n_i && (state_q == S_READ) &&
                       (w_credit < (3'd2 + {2'b00, w_pop}));
    assign bram_re_o = w_issue;
    assign done_o    = done_q;

`ifdef BRAM_CTRL_WRAP_ERR_EN
    localparam int c_sum_w = ADDR_WIDTH + LEN_WIDTH + 1;
    logic [c_sum_w-1:0] w_end;
    logic               err_q;

    assign w_end = c_sum_w'(cmd_addr_i) + c_sum_w'(cmd_len_i);
    assign w_oob = (w_end > c_sum_w'(RAM_DEPTH - 1));
    assign err_o = err_q;

    always_ff @(posedge clk) begin
        if (!rst_n_i) begin
            err_q <= 1'b0;
        end else begin
            err_q <= w_accept && w_oob;
        end
    end
`else
    assign w_oob = 1'b0;
`endif

    always_comb begin
        state_d = state_q;
        addr_d  = addr_q;
        rem_d   = rem_q;
        done_d  = 1'b0;
        case (state_q)
            S_IDLE: begin
                if (w_accept) begin
                    if (w_oob) begin
                        done_d = 1'b1;
                    end else begin
                        addr_d  = cmd_addr_i;
                        rem_d   = cmd_len_i;
                        state_d = cmd_we_i ? S_WRITE : S_READ;
                    end
                end
            end
            S_WRITE: begin
                if (w_wbeat) begin
                    if (rem_q == '0) begin
                        state_d = S_IDLE;
                        done_d  = 1'b1;
                    end else begin
                        addr_d = w_addr_inc;
                        rem_d  = rem_q - LEN_WIDTH'(1);
                    end
                end
            end
            S_READ: begin
                if (w_issue) begin
                    if (rem_q == '0) begin
                        state_d = S_DRAIN;
                    end else begin
                        addr_d = w_addr_inc;
                        rem_d  = rem_q - LEN_WIDTH'(1);
                    end
                end
            end
            S_DRAIN: begin
                if (w_pop && w_head_last) begin
                    state_d = S_IDLE;
                    done_d  = 1'b1;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_comb begin
        count_d = count_q;
        if (w_capture && !w_pop) begin
            count_d = count_q + 2'd1;
        end else if (!w_capture && w_pop) begin
            count_d = count_q - 2'd1;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n_i) begin
            state_q     <= S_IDLE;
            addr_q      <= '0;
            rem_q       <= '0;
            done_q      <= 1'b0;
            mem_q[0]    <= '0;
            mem_q[1]    <= '0;
            last_q      <= 2'b00;
            wptr_q      <= 1'b0;
            rptr_q      <= 1'b0;
            count_q     <= 2'd0;
            inflight_q  <= 1'b0;
            infl_last_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            addr_q      <= addr_d;
            rem_q       <= rem_d;
            done_q      <= done_d;
            count_q     <= count_d;
            inflight_q  <= w_issue;
            infl_last_q <= w_issue && (rem_q == '0);
            if (w_capture) begin
                mem_q[wptr_q]  <= bram_dout_i;
                last_q[wptr_q] <= infl_last_q;
                wptr_q         <= ~wptr_q;
            end
            if (w_pop) begin
                rptr_q <= ~rptr_q;
            end
        end
    end

endmodule

`default_nettype wire

// File: tb/tb_bram_burst_ctrl.sv
// ============================================================================
// Module   : tb_bram_burst_ctrl
// Purpose  : Scoreboard bench for bram_burst_ctrl with a behavioural BRAM.
// Revision : 1.0 - initial release
// ============================================================================
`timescale 1ns/1ps
`default_nettype none

module tb_bram_burst_ctrl;

    localparam int c_depth = 1024;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        cmd_valid, cmd_we;
    logic [9:0]  cmd_addr;
    logic [7:0]  cmd_len;
    logic        wdata_valid;
    logic [15:0] wdata;
    logic        rdata_ready;
    logic        cmd_ready, wdata_ready, rdata_valid, rdata_last, done;
    logic [15:0] rdata;
    logic        bram_we, bram_re;
    logic [9:0]  bram_addr;
    logic [15:0] bram_din, bram_dout;
`ifdef BRAM_CTRL_WRAP_ERR_EN
    logic        err;
`endif

    always #5 clk = ~clk;

    bram_burst_ctrl #(
        .RAM_WIDTH (16),
        .RAM_DEPTH (c_depth),
        .ADDR_WIDTH(10),
        .LEN_WIDTH (8)
    ) u_dut (
        .clk          (clk),
        .rst_n_i      (rst_n),
        .cmd_valid_i  (cmd_valid),
        .cmd_ready_o  (cmd_ready),
        .cmd_we_i     (cmd_we),
        .cmd_addr_i   (cmd_addr),
        .cmd_len_i    (cmd_len),
        .wdata_valid_i(wdata_valid),
        .wdata_ready_o(wdata_ready),
        .wdata_i      (wdata),
        .rdata_valid_o(rdata_valid),
        .rdata_ready_i(rdata_ready),
        .rdata_o      (rdata),
        .rdata_last_o (rdata_last),
        .done_o       (done),
        .bram_we_o    (bram_we),
        .bram_re_o    (bram_re),
        .bram_addr_o  (bram_addr),
        .bram_din_o   (bram_din),
        .bram_dout_i  (bram_dout)
`ifdef BRAM_CTRL_WRAP_ERR_EN
        ,
        .err_o        (err)
`endif
    );

    // Behavioural single-port BRAM with one-cycle registered read
    logic [15:0] ram    [c_depth];
    logic [15:0] shadow [c_depth];
    always @(posedge clk) begin
        if (bram_we) ram[bram_addr] <= bram_din;
        if (bram_re) bram_dout <= ram[bram_addr];
    end

    int checks = 0;
    int errors = 0;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("FAIL %s got %0h expected %0h at %0t", tag, obs, exp, $time);
        end
    endtask

    logic [25:0] wq [$];   // {addr, data}
    logic [16:0] rq [$];   // {last, data}
    logic [15:0] wbuf [16];

    int   we_cnt = 0, re_cnt = 0, rd_pops = 0;
    int   outstanding = 0, max_out = 0;
    logic both_seen = 1'b0;
    logic hold_pend = 1'b0;
    logic [16:0] hold_val;

    always @(negedge clk) begin
        logic [25:0] we_exp;
        logic [16:0] rd_exp;
        if (bram_we && bram_re) both_seen = 1'b1;
        if (bram_we) begin
            we_cnt++;
            check("wr_queue_nonempty", wq.size() != 0, 1);
            if (wq.size() != 0) begin
                we_exp = wq.pop_front();
                check("wr_addr", bram_addr, we_exp[25:16]);
                check("wr_data", bram_din, we_exp[15:0]);
            end
        end
        if (bram_re) re_cnt++;
        if (hold_pend && rst_n)
            check("rd_stable", {rdata_valid, rdata_last, rdata}, {1'b1, hold_val});
        hold_pend = rst_n && rdata_valid && !rdata_ready;
        hold_val  = {rdata_last, rdata};
        if (rdata_valid && rdata_ready) begin
            rd_pops++;
            check("rd_queue_nonempty", rq.size() != 0, 1);
            if (rq.size() != 0) begin
                rd_exp = rq.pop_front();
                check("rd_data", rdata, rd_exp[15:0]);
                check("rd_last", rdata_last, rd_exp[16]);
            end
        end
        if (!rst_n) begin
            outstanding = 0;
        end else begin
            outstanding = outstanding + int'(bram_re) - int'(rdata_valid && rdata_ready);
            if (outstanding > max_out) max_out = outstanding;
        end
    end

    function automatic logic [9:0] next_addr(input logic [9:0] a);
        return (a == 10'(c_depth - 1)) ? 10'd0 : a + 10'd1;
    endfunction

    task automatic send_cmd(input logic we, input logic [9:0] a, input logic [7:0] len,
                            output logic ok);
        cmd_valid = 1'b1; cmd_we = we; cmd_addr = a; cmd_len = len;
        ok = 1'b0;
        for (int i = 0; i < 200 && !ok; i++) begin
            @(negedge clk);
            if (cmd_ready) ok = 1'b1;
            @(posedge clk); #1;
        end
        cmd_valid = 1'b0;
        check("cmd_accept", ok, 1);
    endtask

    task automatic do_write(input logic [9:0] a, input logic [7:0] len);
        logic       ok;
        logic [9:0] ad;
        send_cmd(1'b1, a, len, ok);
        ad = a;
        for (int i = 0; i <= int'(len); i++) begin
            wdata_valid = 1'b1;
            wdata = wbuf[i];
            wq.push_back({ad, wbuf[i]});
            shadow[ad] = wbuf[i];
            @(negedge clk);
            check("wr_ready", wdata_ready, 1);
            @(posedge clk); #1;
            ad = next_addr(ad);
        end
        wdata_valid = 1'b0;
        @(negedge clk);
        check("wr_done", done, 1);
        check("wr_done_not_ready", cmd_ready, 0);
        check("wr_all_beats", wq.size(), 0);
        @(posedge clk); #1;
    endtask

    task automatic push_reads(input logic [9:0] a, input logic [7:0] len);
        logic [9:0] ad;
        ad = a;
        for (int i = 0; i <= int'(len); i++) begin
            rq.push_back({(i == int'(len)), shadow[ad]});
            ad = next_addr(ad);
        end
    endtask

    task automatic run_read(input logic [3:0] pat);
        logic fin;
        fin = 1'b0;
        for (int c = 0; c < 1000 && !fin; c++) begin
            rdata_ready = pat[c % 4];
            @(negedge clk);
            if (done) fin = 1'b1;
            @(posedge clk); #1;
        end
        rdata_ready = 1'b0;
        check("rd_done_seen", fin, 1);
        check("rd_all_beats", rq.size(), 0);
    endtask

    task automatic do_read(input logic [9:0] a, input logic [7:0] len, input logic [3:0] pat);
        logic ok;
        send_cmd(1'b0, a, len, ok);
        push_reads(a, len);
        run_read(pat);
    endtask

    initial begin
        logic ok;
        int   snap;
        for (int i = 0; i < c_depth; i++) begin
            ram[i]    = 16'(i * 37 + 5);
            shadow[i] = 16'(i * 37 + 5);
        end
        bram_dout = '0;
        rst_n = 1'b0; cmd_valid = 1'b0; cmd_we = 1'b0; cmd_addr = '0; cmd_len = '0;
        wdata_valid = 1'b0; wdata = '0; rdata_ready = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        @(negedge clk);
        check("rst_done", done, 0);
        check("rst_rvalid", rdata_valid, 0);
        check("rst_we", bram_we, 0);
        check("rst_re", bram_re, 0);
        check("rst_wready", wdata_ready, 0);
        @(posedge clk); #1;
        rst_n = 1'b1;
        @(negedge clk);
        check("rst_cmd_ready", cmd_ready, 1);
        @(posedge clk); #1;

        wbuf[0] = 16'hABCD; wbuf[1] = 16'h1234; wbuf[2] = 16'h0001; wbuf[3] = 16'hFFFF;
        do_write(10'd0, 8'd3);
        do_read(10'd0, 8'd3, 4'b1111);
        do_read(10'd5, 8'd7, 4'b1001);

`ifdef BRAM_CTRL_WRAP_ERR_EN
        snap = we_cnt;
        send_cmd(1'b1, 10'd1022, 8'd3, ok);
        wdata_valid = 1'b1; wdata = 16'h7777;
        @(negedge clk);
        check("oob_done", done, 1);
        check("oob_err", err, 1);
        check("oob_wready", wdata_ready, 0);
        @(posedge clk); #1;
        wdata_valid = 1'b0;
        check("oob_no_we", we_cnt - snap, 0);
`else
        wbuf[0] = 16'hC0DE; wbuf[1] = 16'hBEEF; wbuf[2] = 16'h0F0F; wbuf[3] = 16'h8001;
        do_write(10'd1022, 8'd3);
        check("wrap_ram_0", ram[0], 16'h0F0F);
        check("wrap_ram_1023", ram[1023], 16'hBEEF);
        do_read(10'd1022, 8'd3, 4'b1111);
`endif

        // Command held through a write burst must wait for the done cycle to pass
        send_cmd(1'b1, 10'd100, 8'd1, ok);
        cmd_valid = 1'b1; cmd_we = 1'b0; cmd_addr = 10'd100; cmd_len = 8'd1;
        for (int i = 0; i < 2; i++) begin
            wdata_valid = 1'b1;
            wdata = 16'h5A00 + 16'(i);
            wq.push_back({10'(100 + i), wdata});
            shadow[100 + i] = wdata;
            @(negedge clk);
            check("hold_busy", cmd_ready, 0);
            @(posedge clk); #1;
        end
        wdata_valid = 1'b0;
        @(negedge clk);
        check("hold_done", done, 1);
        check("hold_done_busy", cmd_ready, 0);
        @(posedge clk); #1;
        @(negedge clk);
        check("hold_accept", cmd_ready, 1);
        @(posedge clk); #1;
        cmd_valid = 1'b0;
        push_reads(10'd100, 8'd1);
        run_read(4'b1111);

        // Reset pulse during beat 3 of a 16-beat read
        send_cmd(1'b0, 10'd0, 8'd15, ok);
        push_reads(10'd0, 8'd15);
        rdata_ready = 1'b1;
        snap = rd_pops;
        for (int c = 0; c < 50 && (rd_pops - snap) < 2; c++) begin
            @(posedge clk); #1;
        end
        rst_n = 1'b0;
        @(posedge clk); #1;
        rst_n = 1'b1;
        rdata_ready = 1'b0;
        rq.delete();
        @(negedge clk);
        check("mid_rst_cmd_ready", cmd_ready, 1);
        check("mid_rst_rvalid", rdata_valid, 0);
        check("mid_rst_re", bram_re, 0);
        snap = re_cnt;
        repeat (5) @(posedge clk);
        #1;
        check("mid_rst_no_re", re_cnt - snap, 0);

        check("we_re_exclusive", both_seen, 0);
        check("max_buffered", max_out <= 2, 1);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

`default_nettype wire
